// File: rtl/seq_mul_unit.sv
// Iterative multiply / multiply-accumulate engine: retires STEP multiplier bits per cycle,
// then applies sign fix-up and accumulation in one extra cycle before pulsing done.
module seq_mul_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             clear,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] acc_hi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [1:0]       flags
);

   localparam int unsigned Iters = WIDTH / STEP;
   localparam int unsigned CntW  = $clog2(Iters + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 neg_q, neg_d;
   logic                 long_q, long_d;
   logic [WIDTH-1:0]     res_lo_q, res_lo_d;
   logic [WIDTH-1:0]     res_hi_q, res_hi_d;
   logic [1:0]           flags_q, flags_d;

   logic                 is_long, is_signed, is_acc;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH+STEP-1:0] partial, sum;
   logic [2*WIDTH-1:0]   fixed;

   // 01x decodes as plain MUL: no accumulate, no long result.
   assign is_long   = mode[2];
   assign is_signed = mode[2] & mode[1];
   assign is_acc    = mode[0] & (mode[2] | ~mode[1]);

   // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
   assign a_abs = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_abs = (is_signed && b[WIDTH-1]) ? -b : b;

   assign partial = {{STEP{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_q[STEP-1:0]};
   assign sum     = {{STEP{1'b0}}, prod_q[2*WIDTH-1:WIDTH]} + partial;
   assign fixed   = (neg_q ? -prod_q : prod_q) + acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      long_d   = long_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      flags_d  = flags_q;

      if (clear) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StRun;
                  cnt_d   = CntW'(Iters);
                  mcand_d = a_abs;
                  prod_d  = {{WIDTH{1'b0}}, b_abs};
                  neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  long_d  = is_long;
                  if (!is_acc) begin
                     acc_d = '0;
                  end else if (is_long) begin
                     acc_d = {acc_hi, acc_lo};
                  end else begin
                     acc_d = {{WIDTH{1'b0}}, acc_lo};
                  end
               end
            end
            StRun: begin
               // Multiplier bits leave from the bottom as the partial sum shifts in on top.
               prod_d = {sum, prod_q[WIDTH-1:STEP]};
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  state_d = StFix;
               end
            end
            StFix: begin
               state_d  = StDone;
               res_lo_d = fixed[WIDTH-1:0];
               if (long_q) begin
                  res_hi_d = fixed[2*WIDTH-1:WIDTH];
                  flags_d  = {fixed[2*WIDTH-1], fixed == '0};
               end else begin
                  res_hi_d = '0;
                  flags_d  = {fixed[WIDTH-1], fixed[WIDTH-1:0] == '0};
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         long_q   <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         long_q   <= long_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         flags_q  <= flags_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);
   assign res_lo = res_lo_q;
   assign res_hi = res_hi_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Randomised and directed bench for seq_mul_unit (STEP=1 and STEP=4 instances) against a
// plain-arithmetic reference model.
module tb_seq_mul_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, start4, clear, clear4;
   logic [2:0]    mode;
   logic [W-1:0]  a, b, acc_lo, acc_hi;

   logic          busy, done, busy4, done4;
   logic [W-1:0]  res_lo, res_hi, res_lo4, res_hi4;
   logic [1:0]    flags, flags4;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0]  prev_lo, prev_hi;
   logic [1:0]    prev_flags;

   seq_mul_unit #(.WIDTH(W), .STEP(1)) dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .mode(mode),
      .a(a), .b(b), .acc_lo(acc_lo), .acc_hi(acc_hi),
      .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi), .flags(flags)
   );

   seq_mul_unit #(.WIDTH(W), .STEP(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .clear(clear4), .mode(mode),
      .a(a), .b(b), .acc_lo(acc_lo), .acc_hi(acc_hi),
      .busy(busy4), .done(done4), .res_lo(res_lo4), .res_hi(res_hi4), .flags(flags4)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] md, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] lo,
                                         input logic [31:0] hi);
      longint sx, sy;
      logic [63:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (md)
         3'b001:  r = {32'd0, 32'(x * y + lo)};
         3'b100:  r = {32'd0, x} * {32'd0, y};
         3'b101:  r = {32'd0, x} * {32'd0, y} + {hi, lo};
         3'b110:  r = 64'(sx * sy);
         3'b111:  r = 64'(sx * sy) + {hi, lo};
         default: r = {32'd0, 32'(x * y)};
      endcase
      return r;
   endfunction

   function automatic logic [1:0] model_flags(input logic [2:0] md, input logic [63:0] r);
      if (md[2]) return {r[63], r == 64'd0};
      return {r[31], r[31:0] == 32'd0};
   endfunction

   function automatic logic sel_done(input int inst);
      return (inst != 0) ? done4 : done;
   endfunction

   function automatic logic sel_busy(input int inst);
      return (inst != 0) ? busy4 : busy;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   task automatic set_start(input int inst, input logic v);
      if (inst != 0) start4 = v;
      else start = v;
   endtask

   task automatic run_op(input int inst, input logic [2:0] md, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] lo, input logic [31:0] hi,
                         input int dup_at, input int clear_at, input bit start_in_done);
      int lat;
      int cyc;
      int busy_low;
      int dones;
      bit seen;
      logic [63:0] er;
      logic [1:0]  ef;
      logic [63:0] got;
      lat = (inst != 0) ? 9 : 33;
      er = model(md, x, y, lo, hi);
      ef = model_flags(md, er);
      seen = 1'b0;
      busy_low = 0;
      cyc = 0;
      @(negedge clk);
      mode = md; a = x; b = y; acc_lo = lo; acc_hi = hi;
      set_start(inst, 1'b1);
      @(posedge clk);
      #1;
      set_start(inst, 1'b0);
      // Latched copies only: scramble the live inputs.
      a = $urandom; b = $urandom; acc_lo = $urandom; acc_hi = $urandom; mode = 3'($urandom);
      while (!seen && cyc < 60) begin
         cyc++;
         if (cyc == dup_at) set_start(inst, 1'b1);
         if (cyc == clear_at) clear = 1'b1;
         @(posedge clk);
         #1;
         set_start(inst, 1'b0);
         if (cyc == clear_at) begin
            clear = 1'b0;
            check_eq("busy_after_clear", 64'(busy), 64'd0);
            dones = 0;
            repeat (40) begin
               @(posedge clk);
               #1;
               if (done) dones++;
            end
            check_eq("no_done_after_clear", 64'(dones), 64'd0);
            check_eq("res_kept_after_clear", {res_hi, res_lo}, {prev_hi, prev_lo});
            check_eq("flags_kept_after_clear", 64'(flags), 64'(prev_flags));
            return;
         end
         if (!sel_busy(inst)) busy_low++;
         if (sel_done(inst)) seen = 1'b1;
      end
      check_eq("done_seen", 64'(seen), 64'd1);
      check_eq("latency", 64'(cyc), 64'(lat));
      check_eq("busy_held", 64'(busy_low), 64'd0);
      got = (inst != 0) ? {res_hi4, res_lo4} : {res_hi, res_lo};
      check_eq("result", got, er);
      check_eq("flags", 64'((inst != 0) ? flags4 : flags), 64'(ef));
      if (inst == 0) begin
         prev_lo = er[31:0]; prev_hi = er[63:32]; prev_flags = ef;
      end
      if (start_in_done) set_start(inst, 1'b1);
      @(posedge clk);
      #1;
      set_start(inst, 1'b0);
      check_eq("done_one_cycle", 64'(sel_done(inst)), 64'd0);
      check_eq("idle_after_done", 64'(sel_busy(inst)), 64'd0);
      if (dup_at > 0) begin
         dones = 0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (sel_done(inst)) dones++;
         end
         check_eq("single_done", 64'(dones), 64'd0);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; start4 = 1'b0; clear = 1'b0; clear4 = 1'b0;
      mode = 3'b000; a = '0; b = '0; acc_lo = '0; acc_hi = '0;
      prev_lo = '0; prev_hi = '0; prev_flags = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_res", {res_hi, res_lo}, 64'd0);
      check_eq("rst_flags", 64'(flags), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op(0, 3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 0, 0, 1'b0);
      run_op(0, 3'b110, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, 0, 0, 1'b0);
      run_op(0, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1'b1);
      run_op(0, 3'b111, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 1'b0);
      run_op(0, 3'b001, 32'h1_0000, 32'h1_0000, 32'd0, 32'd0, 0, 0, 1'b0);
      run_op(1, 3'b001, 32'h1_0000, 32'h1_0000, 32'd0, 32'd0, 0, 0, 1'b0);
      run_op(0, 3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 5, 0, 1'b0);
      run_op(0, 3'b110, 32'h0000_0003, 32'h8000_0001, 32'd0, 32'd0, 0, 10, 1'b0);

      // clear and start together in IDLE
      @(negedge clk);
      start = 1'b1; clear = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; clear = 1'b0;
      check_eq("clear_start_idle", 64'(busy), 64'd0);

      for (int i = 0; i < 30; i++) begin
         run_op(0, 3'($urandom), pick(), pick(), pick(), pick(), 0, 0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         run_op(1, 3'($urandom), pick(), pick(), pick(), pick(), 0, 0, 1'b0);
      end

      // asynchronous reset mid-RUN
      @(negedge clk);
      mode = 3'b100; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_done", 64'(done), 64'd0);
      check_eq("arst_res", {res_hi, res_lo}, 64'd0);
      check_eq("arst_flags", 64'(flags), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_op(0, 3'b000, 32'd3, 32'd3, 32'd0, 32'd0, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
